// File: rtl/mopshub_elink_pkg.sv
// Shared constants, types and helpers for the MOPSHUB uplink e-link framer.
//   UPLINK_FRAME_W : width of one uplink CAN frame
//   PAYLOAD_BYTES  : payload bytes carried per line frame
//   SOP/EOP/IDLE   : line control bytes
//   framer_state_t : byte-level framer state
//   payload_byte() : selects payload byte idx (0..9) of a frame, MSB first
package mopshub_elink_pkg;

  localparam int unsigned UPLINK_FRAME_W = 76;
  localparam int unsigned PAYLOAD_BYTES  = 10;

  localparam logic [7:0] SOP_CODE  = 8'h3C;
  localparam logic [7:0] EOP_CODE  = 8'hBC;
  localparam logic [7:0] IDLE_CODE = 8'hAA;

  typedef logic [UPLINK_FRAME_W-1:0] uplink_frame_t;

  typedef enum logic [2:0] {
    IDLE_BYTE,
    SOP,
    PAYLOAD,
    CHK,
    EOP
  } framer_state_t;

  // Frame is zero-padded to 80 bits so byte0 carries the top nibble f[75:72].
  function automatic logic [7:0] payload_byte(input uplink_frame_t f, input logic [3:0] idx);
    logic [79:0] padded;
    logic [6:0]  lsb;
    padded = {4'h0, f};
    lsb    = 7'(4'd9 - idx) * 7'd8;
    return padded[lsb +: 8];
  endfunction

endpackage

// File: rtl/elink_uplink_framer_if.sv
// Upstream valid/ready frame handshake into the e-link framer.
//   frame_in    : uplink CAN frame, bit 75 = MSB
//   frame_valid : frame_in valid
//   frame_ready : framer buffer can accept
interface elink_uplink_framer_if;
  import mopshub_elink_pkg::*;

  uplink_frame_t frame_in;
  logic          frame_valid;
  logic          frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);

endinterface

// File: rtl/uplink_frame_fifo.sv
// Synchronous first-word-fall-through FIFO of uplink frames.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i (ignored while full)
//   wdata_i   : frame to store
//   pop_i     : drop head entry (ignored while empty)
//   rdata_o   : head entry, valid while !empty_o
//   full_o    : FIFO_DEPTH entries held
//   empty_o   : no entries held
module uplink_frame_fifo
  import mopshub_elink_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  uplink_frame_t wdata_i,
  input  logic          pop_i,
  output uplink_frame_t rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);

  uplink_frame_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_BITS'(push_ok) - CNT_BITS'(pop_ok);
    end
  end

endmodule

// File: rtl/elink_uplink_framer.sv
// Buffers uplink CAN frames and serialises each as SOP | 10 payload | XOR | EOP
// onto the 2-bit e-link, MSB first, one bit-pair per clk; idles with 0xAA.
//   clk, rst        : e-link word clock, asynchronous active-high reset
//   enable          : allow new frames to start (current frame always completes)
//   up_if           : frame_in / frame_valid / frame_ready handshake
//   tx_elink2bit    : registered serial output
//   busy            : framer active or frames queued
//   frame_sent      : 1-clk pulse aligned with the last EOP pair on the line
//   frames_sent_cnt : completed-frame counter, wraps
module elink_uplink_framer
  import mopshub_elink_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  elink_uplink_framer_if.slave  up_if,
  output logic [1:0]            tx_elink2bit,
  output logic                  busy,
  output logic                  frame_sent,
  output logic [CNT_W-1:0]      frames_sent_cnt
);

  uplink_frame_t fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_c;
  logic          start_ok_c;
  logic [7:0]    cur_byte_c;

  framer_state_t state_q, state_d;
  logic [1:0]    pair_cnt_q, pair_cnt_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  uplink_frame_t frame_q, frame_d;
  logic [7:0]    chk_q, chk_d;
  logic [1:0]    tx_q, tx_d;
  logic          sent_q, sent_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  assign up_if.frame_ready = !fifo_full;
  assign tx_elink2bit      = tx_q;
  assign busy              = busy_q;
  assign frame_sent        = sent_q;
  assign frames_sent_cnt   = cnt_q;

  uplink_frame_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (up_if.frame_valid),
    .wdata_i (up_if.frame_in),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Byte currently being shifted out.
  always_comb begin
    cur_byte_c = IDLE_CODE;
    case (state_q)
      SOP:     cur_byte_c = SOP_CODE;
      PAYLOAD: cur_byte_c = payload_byte(frame_q, byte_cnt_q);
      CHK:     cur_byte_c = chk_q;
      EOP:     cur_byte_c = EOP_CODE;
      default: cur_byte_c = IDLE_CODE;
    endcase
  end

  // Next-state / output logic; the FSM only moves on the last pair of a byte.
  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q + 2'd1;
    byte_cnt_d = byte_cnt_q;
    frame_d    = frame_q;
    chk_d      = chk_q;
    cnt_d      = cnt_q;
    sent_d     = 1'b0;
    pop_c      = 1'b0;
    start_ok_c = enable && !fifo_empty;
    busy_d     = (state_q != IDLE_BYTE) || !fifo_empty;
    tx_d       = 2'(cur_byte_c >> (3'd6 - {pair_cnt_q, 1'b0}));

    if (pair_cnt_q == 2'd3) begin
      case (state_q)
        IDLE_BYTE: begin
          if (start_ok_c) begin
            pop_c   = 1'b1;
            frame_d = fifo_rdata;
            chk_d   = '0;
            state_d = SOP;
          end
        end
        SOP: begin
          byte_cnt_d = '0;
          state_d    = PAYLOAD;
        end
        PAYLOAD: begin
          chk_d = chk_q ^ cur_byte_c;
          if (byte_cnt_q == 4'(PAYLOAD_BYTES - 1)) state_d = CHK;
          else byte_cnt_d = byte_cnt_q + 4'd1;
        end
        CHK: state_d = EOP;
        EOP: begin
          sent_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          // Back-to-back: next SOP follows EOP without an idle byte.
          if (start_ok_c) begin
            pop_c   = 1'b1;
            frame_d = fifo_rdata;
            chk_d   = '0;
            state_d = SOP;
          end else begin
            state_d = IDLE_BYTE;
          end
        end
        default: state_d = IDLE_BYTE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE_BYTE;
      pair_cnt_q <= '0;
      byte_cnt_q <= '0;
      frame_q    <= '0;
      chk_q      <= '0;
      tx_q       <= 2'b10;
      sent_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      frame_q    <= frame_d;
      chk_q      <= chk_d;
      tx_q       <= tx_d;
      sent_q     <= sent_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule
